// File: rtl/sha3_pkg.sv
// Shared widths and packer FSM encoding for the keccak byte-stream front end.
package sha3_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BYTE_NUM_W = 2;

    typedef enum logic [1:0] {FILL, SEND, PAD} packer_state_t;

    // Byte lane idx sits at bits [31-8*idx -: 8]: the first byte lands in the MSB lane.
    function automatic logic [WORD_W-1:0] insert_byte(input logic [WORD_W-1:0]     word,
                                                      input logic [BYTE_NUM_W-1:0] idx,
                                                      input logic [BYTE_W-1:0]     data);
        logic [WORD_W-1:0] w;
        w = word;
        w[WORD_W - 1 - BYTE_W * int'(idx) -: BYTE_W] = data;
        return w;
    endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs an 8-bit valid/ready byte stream into 32-bit words for the keccak core.
// Optional message length counter is built when PACKER_BYTE_COUNT_EN is defined.
module keccak_byte_packer
    import sha3_pkg::*;
`ifdef PACKER_BYTE_COUNT_EN
#(
    parameter int unsigned COUNT_W = 32
)
`endif
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  msg_start,
    output logic [WORD_W-1:0]     in,
    output logic                  in_ready,
    output logic                  is_last,
    output logic [BYTE_NUM_W-1:0] byte_num,
    input  logic                  buffer_full
`ifdef PACKER_BYTE_COUNT_EN
    ,
    output logic [COUNT_W-1:0]    msg_len,
    output logic                  msg_len_valid
`endif
);

    localparam int unsigned LANES = WORD_W / BYTE_W;

    packer_state_t         state_q, state_d;
    logic [BYTE_NUM_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_NUM_W-1:0] bn_q, bn_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  pad_q, pad_d;
    logic                  accept, xfer, word_done;

    assign accept    = s_valid & s_ready;
    assign xfer      = in_ready & ~buffer_full;
    assign word_done = accept & (s_last | (cnt_q == BYTE_NUM_W'(LANES - 1)));
    assign msg_start = accept & first_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            word_q  <= '0;
            bn_q    <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            bn_q    <= bn_d;
            first_q <= first_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        bn_d    = bn_q;
        first_d = first_q;
        last_d  = last_q;
        pad_d   = pad_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    word_d  = insert_byte(word_q, cnt_q, s_data);
                    cnt_d   = cnt_q + 1'b1;
                    first_d = 1'b0;
                    if (word_done) begin
                        state_d = SEND;
                        last_d  = s_last;
                        bn_d    = s_last ? BYTE_NUM_W'(cnt_q + 1'b1) : '0;
                        // A message ending on a full word needs a separate zero word to carry is_last.
                        pad_d   = s_last & (cnt_q == BYTE_NUM_W'(LANES - 1));
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    state_d = pad_q ? PAD : FILL;
                    cnt_d   = '0;
                    word_d  = '0;
                    bn_d    = '0;
                    last_d  = 1'b0;
                    pad_d   = 1'b0;
                    if (last_q && !pad_q) begin
                        first_d = 1'b1;
                    end
                end
            end
            PAD: begin
                if (xfer) begin
                    state_d = FILL;
                    first_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_ready  = 1'b0;
        in       = '0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = '0;
        unique case (state_q)
            FILL: s_ready = reset;
            SEND: begin
                in       = word_q;
                in_ready = 1'b1;
                is_last  = last_q & ~pad_q;
                byte_num = pad_q ? '0 : bn_q;
            end
            PAD: begin
                in_ready = 1'b1;
                is_last  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PACKER_BYTE_COUNT_EN
    logic [COUNT_W-1:0] len_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
        end else if (msg_start) begin
            len_q <= COUNT_W'(1);
        end else if (accept && (len_q != '1)) begin
            len_q <= len_q + 1'b1;
        end
    end

    assign msg_len       = len_q;
    assign msg_len_valid = xfer & is_last;
`endif

endmodule
